// File: rtl/servo_pwm_gen.sv
// -----------------------------------------------------------------------------
// servo_pwm_gen
//
// Dual-channel hobby-servo pulse generator. Each 8-bit command is converted to
// a pulse width of MIN_US + cmd*STEP_US microseconds, clamped to MAX_US, and
// emitted once per PERIOD_US frame. Commands and enable are sampled only on the
// frame wrap edge, so a pulse in flight is never shortened or stretched.
//
// Optional feature macro:
//   SERVO_SLEW_EN  - when defined, a running channel moves toward its target by
//                    at most SLEW_US per frame. Off -> on is always a direct
//                    jump. When undefined, the width follows the target every
//                    frame and no slew logic exists.
//
// Ports:
//   clk_clk        in   1  system clock (CLK_HZ)
//   reset_reset_n  in   1  asynchronous active-low reset
//   cmd0           in   8  channel 0 command
//   cmd1           in   8  channel 1 command
//   enable         in   1  outputs active when high (sampled at frame wrap)
//   pwm_out        out  2  registered servo pulses, bit n = channel n
//   frame_strobe   out  1  registered one-cycle pulse on first cycle of a frame
// -----------------------------------------------------------------------------
module servo_pwm_gen #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int PERIOD_US = 20000,
    parameter int MIN_US    = 1000,
    parameter int STEP_US   = 4,
    parameter int MAX_US    = 2000,
    parameter int SLEW_US   = 20
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic [7:0] cmd0,
    input  logic [7:0] cmd1,
    input  logic       enable,
    output logic [1:0] pwm_out,
    output logic       frame_strobe
);

    localparam int DIV = CLK_HZ / 1_000_000;
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    // Widths share the microsecond counter's width: MAX_US < PERIOD_US.
    localparam int PW  = $clog2(PERIOD_US + 1);

    localparam logic [DW-1:0] PRE_LAST = DW'(DIV - 1);
    localparam logic [PW-1:0] US_LAST  = PW'(PERIOD_US - 1);
    localparam logic [PW-1:0] W_MAX    = PW'(MAX_US);

    // Reject parameter sets the counters and clamp cannot represent.
    if ((CLK_HZ < 1_000_000) || ((CLK_HZ % 1_000_000) != 0) ||
        (MIN_US > MAX_US) || (MAX_US >= PERIOD_US) || (SLEW_US < 0)) begin : g_cfg_err
        $error("servo_pwm_gen: invalid parameter set");
    end

    // Command byte to clamped pulse width in microseconds (wide intermediate).
    function automatic logic [PW-1:0] calc_target(input logic [7:0] cmd);
        logic [31:0] raw;
        raw = 32'(MIN_US) + (32'(cmd) * 32'(STEP_US));
        if (raw > 32'(MAX_US)) begin
            calc_target = W_MAX;
        end else begin
            calc_target = raw[PW-1:0];
        end
    endfunction

`ifdef SERVO_SLEW_EN
    // Move cur toward tgt by at most SLEW_US; land exactly on tgt when close.
    function automatic logic [PW-1:0] slew_step(input logic [PW-1:0] cur,
                                                input logic [PW-1:0] tgt);
        logic [31:0] c32;
        logic [31:0] t32;
        logic [31:0] lim;
        c32 = 32'(cur);
        t32 = 32'(tgt);
        lim = 32'(SLEW_US);
        if (t32 >= c32) begin
            if ((t32 - c32) <= lim) begin
                slew_step = tgt;
            end else begin
                slew_step = PW'(c32 + lim);
            end
        end else begin
            if ((c32 - t32) <= lim) begin
                slew_step = tgt;
            end else begin
                slew_step = PW'(c32 - lim);
            end
        end
    endfunction
`endif

    // Width for the next frame. A zero width is the off state and always
    // jumps straight to the target rather than ramping up from nothing.
    function automatic logic [PW-1:0] next_width(input logic [PW-1:0] cur,
                                                 input logic [PW-1:0] tgt,
                                                 input logic          en);
        if (!en) begin
            next_width = {PW{1'b0}};
        end else if (cur == {PW{1'b0}}) begin
            next_width = tgt;
        end else begin
`ifdef SERVO_SLEW_EN
            next_width = slew_step(cur, tgt);
`else
            next_width = tgt;
`endif
        end
    endfunction

    logic [DW-1:0]        pre_q, pre_d;
    logic [PW-1:0]        us_q, us_d;
    logic [1:0][PW-1:0]   width_q, width_d;
    logic [1:0]           pwm_d;
    logic                 strobe_d;
    logic                 pre_last_s;
    logic                 wrap_s;

    // Next-state logic. Outputs are computed from the next counter/width
    // values so the registered pulse rises on the same edge as the strobe.
    always_comb begin
        pre_last_s = (pre_q == PRE_LAST);
        wrap_s     = pre_last_s && (us_q == US_LAST);

        if (pre_last_s) begin
            pre_d = {DW{1'b0}};
            if (us_q == US_LAST) begin
                us_d = {PW{1'b0}};
            end else begin
                us_d = us_q + PW'(1'b1);
            end
        end else begin
            pre_d = pre_q + DW'(1'b1);
            us_d  = us_q;
        end

        if (wrap_s) begin
            width_d[0] = next_width(width_q[0], calc_target(cmd0), enable);
            width_d[1] = next_width(width_q[1], calc_target(cmd1), enable);
        end else begin
            width_d = width_q;
        end

        pwm_d[0] = (us_d < width_d[0]);
        pwm_d[1] = (us_d < width_d[1]);
        strobe_d = (pre_d == {DW{1'b0}}) && (us_d == {PW{1'b0}});
    end

    // State and output registers; reset silences both channels immediately.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pre_q        <= {DW{1'b0}};
            us_q         <= {PW{1'b0}};
            width_q      <= {(2*PW){1'b0}};
            pwm_out      <= 2'b00;
            frame_strobe <= 1'b0;
        end else begin
            pre_q        <= pre_d;
            us_q         <= us_d;
            width_q      <= width_d;
            pwm_out      <= pwm_d;
            frame_strobe <= strobe_d;
        end
    end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// -----------------------------------------------------------------------------
// tb_servo_pwm_gen
//
// Directed bench for servo_pwm_gen at CLK_HZ=4 MHz (DIV=4), PERIOD_US=100,
// MIN_US=10, STEP_US=1, MAX_US=40, SLEW_US=5, so a frame is 400 cycles and
// one microsecond is 4 cycles. The stimulus process pushes the expected
// per-frame pulse lengths into a queue; the monitor delimits frames with
// frame_strobe (or reset release) and compares measured high-cycle counts,
// frame length and pulse shape against the popped entry.
// -----------------------------------------------------------------------------
module tb_servo_pwm_gen;

    localparam int FRAME = 400;
    localparam int BOUND = 3000;

    logic       clk;
    logic       rst_n;
    logic [7:0] cmd0;
    logic [7:0] cmd1;
    logic       enable;
    logic [1:0] pwm_out;
    logic       frame_strobe;

    typedef struct {
        int w0;
        int w1;
        int len;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   frames_done;
    int   cyc;
    int   ramp [6];
    int   f9_ch1;
    int   f10_ch0;

    servo_pwm_gen #(
        .CLK_HZ   (4_000_000),
        .PERIOD_US(100),
        .MIN_US   (10),
        .STEP_US  (1),
        .MAX_US   (40),
        .SLEW_US  (5)
    ) dut (
        .clk_clk      (clk),
        .reset_reset_n(rst_n),
        .cmd0         (cmd0),
        .cmd1         (cmd1),
        .enable       (enable),
        .pwm_out      (pwm_out),
        .frame_strobe (frame_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic push(input int w0, input int w1);
        exp_t e;
        e.w0  = w0;
        e.w1  = w1;
        e.len = FRAME;
        exp_q.push_back(e);
    endtask

    // Advance to the cycle with index c of the frame following frame f.
    task automatic wait_at(input int f, input int c, input string what);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (!((frames_done == f) && (cyc == c)) && (n < BOUND));
        checks++;
        if (!((frames_done == f) && (cyc == c))) begin
            errors++;
            $display("FAIL wait_%s actual=frames %0d cycle %0d expected=frames %0d cycle %0d",
                     what, frames_done, cyc, f, c);
        end
    endtask

    // Monitor: measures each frame and compares against the scoreboard.
    initial begin : monitor
        int         cnt;
        int         hi0;
        int         hi1;
        logic [1:0] prev;
        logic [1:0] late_rise;
        exp_t       e;
        cnt = 0; hi0 = 0; hi1 = 0; prev = 2'b00; late_rise = 2'b00;
        frames_done = 0;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cnt = 0; hi0 = 0; hi1 = 0; prev = 2'b00; late_rise = 2'b00;
            end else begin
                if (frame_strobe && (cnt != 0)) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL frame%0d_unexpected actual=frame seen expected=none",
                                 frames_done + 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("frame%0d_len", frames_done + 1), cnt, e.len);
                        chk($sformatf("frame%0d_ch0_high", frames_done + 1), hi0, e.w0);
                        chk($sformatf("frame%0d_ch1_high", frames_done + 1), hi1, e.w1);
                        chk($sformatf("frame%0d_shape", frames_done + 1), int'(late_rise), 0);
                    end
                    frames_done++;
                    cnt = 0; hi0 = 0; hi1 = 0; late_rise = 2'b00;
                end
                // Any rise after the first cycle means the pulse is not
                // aligned with the frame start.
                if (cnt != 0) begin
                    late_rise = late_rise | (pwm_out & ~prev);
                end
                hi0 += int'(pwm_out[0]);
                hi1 += int'(pwm_out[1]);
                prev = pwm_out;
                cyc  = cnt;
                cnt++;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        checks = 0;
        errors = 0;
`ifdef SERVO_SLEW_EN
        ramp    = '{60, 80, 100, 120, 140, 160};
        f9_ch1  = 140;
        f10_ch0 = 140;
`else
        ramp    = '{160, 160, 160, 160, 160, 160};
        f9_ch1  = 160;
        f10_ch0 = 80;
`endif
        rst_n  = 1'b0;
        cmd0   = 8'd0;
        cmd1   = 8'd20;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("reset_pwm", int'(pwm_out), 0);
        chk("reset_strobe", int'(frame_strobe), 0);

        // Frame 1 silent; frame 2: 10 us and 30 us.
        push(0, 0);
        push(40, 120);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Step 0 -> 30 from steady state (ramp only with slew).
        wait_at(1, 0, "f2_start");
        cmd0 = 8'd30;
        for (int i = 0; i < 6; i++) begin
            push(ramp[i], 120);
        end

        // Clamp on both channels: 210 us and 265 us both limit to 40 us.
        wait_at(7, 0, "f8_start");
        cmd0 = 8'd200;
        cmd1 = 8'd255;
        push(160, f9_ch1);

        wait_at(8, 0, "f9_start");
        cmd0 = 8'd10;
        push(f10_ch0, 160);

        // Mid-frame change at us_cnt=5 only takes effect next frame.
        wait_at(9, 21, "f10_us5");
        cmd0 = 8'd30;
        push(160, 160);

        // Enable dropped mid-pulse: current pulse completes, next frame off.
        wait_at(10, 60, "f11_midpulse");
        enable = 1'b0;
        push(0, 0);

        wait_at(11, 0, "f12_start");
        enable = 1'b1;
        cmd1   = 8'd20;

        // Reset at us_cnt=3 of a 40 us pulse drops the outputs at once.
        wait_at(12, 13, "f13_us3");
        chk("prereset_pwm", int'(pwm_out), 3);
        rst_n = 1'b0;
        #1;
        chk("midreset_pwm", int'(pwm_out), 0);
        chk("midreset_strobe", int'(frame_strobe), 0);
        push(0, 0);
        push(160, 120);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        wait_at(14, 0, "after_reset_f2_end");
        chk("scoreboard_left", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
